// File: rtl/boreal_pkg.sv
// Shared definitions for the boreal feature extractor/synthesizer pair:
// widths, the spatial weight table and the synthesizer state encoding.
package boreal_pkg;

    localparam int N_CH_DEFAULT = 8;
    localparam int SAMPLE_W     = 16;
    localparam int WEIGHT_W     = 8;

    // One table for both ends so analysis and reconstruction stay matched.
    localparam logic signed [WEIGHT_W-1:0] WX [0:7] = '{
        8'sd32, 8'sd24, 8'sd16, 8'sd8, -8'sd8, -8'sd16, -8'sd24, -8'sd32
    };
    localparam logic signed [WEIGHT_W-1:0] WY [0:7] = '{
        -8'sd8, -8'sd16, -8'sd24, -8'sd32, 8'sd32, 8'sd24, 8'sd16, 8'sd8
    };

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/boreal_weight_mac.sv
// Back-projection of one channel: (fx*wx + fy*wy) >>> SHIFT, reduced to 16 bits.
// BOREAL_SAT_EN selects saturation; otherwise the result wraps.
module boreal_weight_mac
    import boreal_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic [SAMPLE_W-1:0] fx,
    input  logic [SAMPLE_W-1:0] fy,
    input  logic [2:0]          ch,
    output logic [SAMPLE_W-1:0] sample
);

    logic signed [23:0] prod_x;
    logic signed [23:0] prod_y;
    logic signed [31:0] sum;
    logic signed [31:0] shifted;

    always_comb begin
        prod_x  = 24'(signed'(fx)) * 24'(WX[ch]);
        prod_y  = 24'(signed'(fy)) * 24'(WY[ch]);
        sum     = 32'(prod_x) + 32'(prod_y);
        shifted = sum >>> SHIFT;
`ifdef BOREAL_SAT_EN
        if (shifted > 32'sd32767) begin
            sample = 16'h7FFF;
        end else if (shifted < -32'sd32768) begin
            sample = 16'h8000;
        end else begin
            sample = shifted[15:0];
        end
`else
        sample = shifted[15:0];
`endif
    end

`ifndef BOREAL_SAT_EN
    logic unused_hi;
    assign unused_hi = ^shifted[31:16];
`endif

endmodule

// File: rtl/boreal_feature_synth.sv
// Feature-pair to 8-channel sample synthesizer; streams one frame per accepted pair.
// Build option BOREAL_SAT_EN saturates samples instead of wrapping.
//
// state | meaning
// IDLE  | no frame in flight, waiting for a feature pair
// EMIT  | presenting channels 0..N_CH-1 of the captured pair
module boreal_feature_synth
    import boreal_pkg::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] feature_x,
    input  logic [15:0] feature_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sample_out,
    output logic [2:0]  out_ch,
    output logic        out_last
);

    localparam logic [2:0] LAST_CH = 3'(N_CH - 1);

    state_e      state_q, state_d;
    logic [15:0] fx_q, fx_d;
    logic [15:0] fy_q, fy_d;
    logic [15:0] sample_q, sample_d;
    logic [2:0]  ch_q, ch_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        accept, accept_last, load;
    logic [15:0] mac_sample;

    assign accept      = out_valid_q & out_ready;
    assign accept_last = accept & out_last_q;
    // Ready again in the cycle the last channel leaves: no bubble between frames.
    assign in_ready    = (state_q == IDLE) | accept_last;

    always_comb begin
        state_d     = state_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        ch_d        = ch_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        load        = 1'b0;
        if (in_valid && in_ready) begin
            fx_d        = feature_x;
            fy_d        = feature_y;
            ch_d        = 3'd0;
            out_valid_d = 1'b1;
            state_d     = EMIT;
            load        = 1'b1;
        end else if (accept_last) begin
            ch_d        = 3'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
        end else if (accept) begin
            ch_d = ch_q + 3'd1;
            load = 1'b1;
        end
        if (load) begin
            out_last_d = (ch_d == LAST_CH);
        end
    end

    // The MAC sees the channel and pair being loaded so the sample is registered with them.
    boreal_weight_mac #(.SHIFT(SHIFT)) u_mac (
        .fx     (fx_d),
        .fy     (fy_d),
        .ch     (ch_d),
        .sample (mac_sample)
    );

    always_comb begin
        sample_d = load ? mac_sample : sample_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fx_q        <= '0;
            fy_q        <= '0;
            sample_q    <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            sample_q    <= sample_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign sample_out = sample_q;
    assign out_ch     = ch_q;
    assign out_last   = out_last_q;

endmodule
